// File: rtl/pipelined_mem_responder.sv
// Word-addressed memory responder for cache fills; byte address bit 0 ignored, contents survive reset.
// Latency: read data and a one-cycle data_valid strobe appear LATENCY cycles after issue, fully pipelined.
// Backpressure: none by default; with MEM_STALL_EN defined, stall freezes the pipeline and busy reports activity.
module pipelined_mem_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid
`ifdef MEM_STALL_EN
   ,
   input  logic                  stall,
   output logic                  busy
`endif
);

   localparam int WAW   = ADDR_WIDTH - 1;
   localparam int DEPTH = 1 << WAW;

   generate
      if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
         $fatal(1, "pipelined_mem_responder: LATENCY must be in 1..8");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [LATENCY-1:0]    vld_q, vld_d;
   logic [DATA_WIDTH-1:0] dat_q [LATENCY];
   logic [DATA_WIDTH-1:0] dat_d [LATENCY];
   logic                  data_valid_q, data_valid_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   logic [WAW-1:0] word_addr;
   logic           addr_lsb_unused;
   logic           advance;
   logic           rd_issue;
   logic           mem_we;

   assign word_addr       = address[ADDR_WIDTH-1:1];
   assign addr_lsb_unused = address[0];

`ifdef MEM_STALL_EN
   assign advance = ~stall;
   assign busy    = stall | (|vld_q);
`else
   assign advance = 1'b1;
`endif

   assign rd_issue = advance & enable & ~wr;
   // Gated by rst so requests presented during reset never reach storage.
   assign mem_we   = rst & advance & enable & wr;

   always_comb begin
      vld_d        = vld_q;
      dat_d        = dat_q;
      data_valid_d = 1'b0;
      data_out_d   = data_out_q;
      if (advance) begin
         vld_d[0] = rd_issue;
         dat_d[0] = rd_issue ? mem_q[word_addr] : '0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
         data_valid_d = vld_q[LATENCY-1];
         if (vld_q[LATENCY-1]) begin
            data_out_d = dat_q[LATENCY-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q        <= '0;
         dat_q        <= '{default: '0};
         data_valid_q <= 1'b0;
         data_out_q   <= '0;
      end else begin
         vld_q        <= vld_d;
         dat_q        <= dat_d;
         data_valid_q <= data_valid_d;
         data_out_q   <= data_out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[word_addr] <= data_in;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Self-checking bench for pipelined_mem_responder: vector table plus hand sequences, scoreboard on read returns.
module tb_pipelined_mem_responder;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          wr;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          data_valid;
`ifdef MEM_STALL_EN
   logic          stall;
   logic          busy;
`endif

   always #5 clk = ~clk;

   pipelined_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .wr         (wr),
      .address    (address),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid)
`ifdef MEM_STALL_EN
      ,
      .stall      (stall),
      .busy       (busy)
`endif
   );

   typedef struct {
      logic          en;
      logic          wr;
      logic [15:0]   addr;
      logic [15:0]   din;
      logic [15:0]   exp;
   } vec_t;

   typedef struct {
      logic [15:0] dat;
      int          due;
   } sb_t;

   vec_t vt[$];
   sb_t  sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en    = 1'b0;
   bit   chk_idle  = 1'b0;
   bit   chk_busy  = 1'b0;
   bit   chk_empty = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic en, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] e);
      vec_t v;
      v.en = en; v.wr = w; v.addr = a; v.din = d; v.exp = e;
      return v;
   endfunction

   // Presents one request; it is issued at the next rising edge (cyc + 1).
   task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
      @(posedge clk);
      #1;
      enable  = en;
      wr      = w;
      address = a;
      data_in = d;
   endtask

   task automatic push_rd(input logic [15:0] exp, input int extra);
      sb_t s;
      s.dat = exp;
      s.due = cyc + 1 + LAT + extra;
      sb.push_back(s);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (chk_idle) begin
            checks++;
            if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
               errors++;
               $display("FAIL idle_zero cyc=%0d data_valid=%b data_out=%h required 0/0000",
                        cyc, data_valid, data_out);
            end
         end
         if (data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid cyc=%0d data_out=%h required no data_valid", cyc, data_out);
            end else begin
               if (sb[0].due != cyc || sb[0].dat !== data_out) begin
                  errors++;
                  $display("FAIL rd_data cyc=%0d data_out=%h required cyc=%0d data=%h",
                           cyc, data_out, sb[0].due, sb[0].dat);
               end
               void'(sb.pop_front());
            end
         end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_valid cyc=%0d data_valid=%b required 1 with data=%h",
                     cyc, data_valid, sb[0].dat);
            void'(sb.pop_front());
         end
`ifdef MEM_STALL_EN
         if (chk_busy) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL busy cyc=%0d busy=%b required 1", cyc, busy);
            end
         end
`endif
         if (chk_empty) begin
            checks++;
            if (sb.size() != 0) begin
               errors++;
               $display("FAIL sb_drain outstanding=%0d required 0", sb.size());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d required completion", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; enable = 1'b0; wr = 1'b0; address = '0; data_in = '0;
`ifdef MEM_STALL_EN
      stall = 1'b0;
`endif
      for (int i = 0; i < 8; i++) vt.push_back(mk(1'b1, 1'b1, 16'h0040 + 16'(2*i), 16'h1000 + 16'(i), 16'h0));
      for (int i = 0; i < 8; i++) vt.push_back(mk(1'b1, 1'b0, 16'h0040 + 16'(2*i), 16'h0, 16'h1000 + 16'(i)));
      vt.push_back(mk(1'b1, 1'b1, 16'h0046, 16'h4567, 16'h0));
      vt.push_back(mk(1'b1, 1'b0, 16'h0046, 16'h0,    16'h4567));
      vt.push_back(mk(1'b1, 1'b0, 16'h0047, 16'h0,    16'h4567));
      vt.push_back(mk(1'b1, 1'b0, 16'h0040, 16'h0,    16'h1000));
      vt.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0,    16'h0));
      vt.push_back(mk(1'b1, 1'b0, 16'h0042, 16'h0,    16'h1001));
      vt.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0,    16'h0));
      vt.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0,    16'h0));
      vt.push_back(mk(1'b1, 1'b0, 16'h0044, 16'h0,    16'h1002));
      vt.push_back(mk(1'b1, 1'b0, 16'h0048, 16'h0,    16'h1004));
      vt.push_back(mk(1'b1, 1'b1, 16'h0048, 16'hBEEF, 16'h0));
      vt.push_back(mk(1'b1, 1'b0, 16'h0048, 16'h0,    16'hBEEF));
      vt.push_back(mk(1'b1, 1'b0, 16'h0049, 16'h0,    16'hBEEF));
      vt.push_back(mk(1'b0, 1'b1, 16'h0040, 16'hDEAD, 16'h0));
      vt.push_back(mk(1'b1, 1'b0, 16'h0040, 16'h0,    16'h1000));
      vt.push_back(mk(1'b1, 1'b1, 16'hFFFE, 16'hA5A5, 16'h0));
      vt.push_back(mk(1'b1, 1'b0, 16'hFFFF, 16'h0,    16'hA5A5));

      @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      chk_idle = 1'b1;
      repeat (10) step(1'b0, 1'b0, 16'h0, 16'h0);
      chk_idle = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].en, vt[i].wr, vt[i].addr, vt[i].din);
         if (vt[i].en && !vt[i].wr) push_rd(vt[i].exp, 0);
      end
      repeat (LAT + 3) step(1'b0, 1'b0, 16'h0, 16'h0);

      // Reset lands right after the second read issues; the third read is presented during reset.
      step(1'b1, 1'b0, 16'h0040, 16'h0);
      step(1'b1, 1'b0, 16'h0042, 16'h0);
      @(posedge clk);
      #1 rst = 1'b0; enable = 1'b1; wr = 1'b0; address = 16'h0044;
      @(posedge clk);
      #1 rst = 1'b1; enable = 1'b0;
      chk_idle = 1'b1;
      repeat (LAT + 3) step(1'b0, 1'b0, 16'h0, 16'h0);
      chk_idle = 1'b0;
      step(1'b1, 1'b0, 16'h0042, 16'h0); push_rd(16'h1001, 0);
      step(1'b1, 1'b0, 16'h0044, 16'h0); push_rd(16'h1002, 0);
      step(1'b1, 1'b0, 16'h0046, 16'h0); push_rd(16'h4567, 0);
      repeat (LAT + 3) step(1'b0, 1'b0, 16'h0, 16'h0);

`ifdef MEM_STALL_EN
      step(1'b1, 1'b0, 16'h0046, 16'h0); push_rd(16'h4567, 3);
      @(posedge clk);
      #1 enable = 1'b0; stall = 1'b1; chk_busy = 1'b1;
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1 stall = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk);
      #1 chk_busy = 1'b0;
      repeat (LAT + 2) step(1'b0, 1'b0, 16'h0, 16'h0);
`endif

      chk_empty = 1'b1;
      @(negedge clk);
      #1 chk_empty = 1'b0;
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_mem_responder.md
Name: pipelined_mem_responder

Overview:
- Memory-side responder for the cache fill protocol: accepts one word request per cycle from the cache fill FSM or the write path.
- Returns read data with a fixed, pipelined latency and a one-cycle data-valid strobe.
- Sits below the I- and D-cache fill FSMs as the main-memory model, or behind the memory arbiter when both caches share it.
- Word-addressed storage; byte address bit 0 is ignored.

Parameters:
- ADDR_WIDTH, 16, width of the byte address; storage depth = 2^(ADDR_WIDTH-1) words.
- DATA_WIDTH, 16, word width.
- LATENCY, 4, cycles from read issue to data_valid. Legal range 1..8; out-of-range values are a $fatal at elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- enable  in  1  request strobe; a request is issued each cycle enable=1.
- wr  in  1  1 = write request, 0 = read request; qualified by enable.
- address  in  ADDR_WIDTH  byte address; address[0] is ignored.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data, meaningful only while data_valid=1.
- data_valid  out  1  one-cycle strobe per completed read.

Behaviour:
- Reset (rst=0 at posedge):
  - All pipeline valid bits clear; data_valid=0, data_out=0 the following cycle.
  - Storage contents are NOT cleared.
  - Requests presented during reset are ignored.
- Reset mid-operation: all in-flight reads are discarded, and no data_valid is produced for them after reset deasserts.
- Write (enable=1, wr=1):
  - mem[address[ADDR_WIDTH-1:1]] <= data_in at that posedge.
  - No data_valid is generated.
  - Pipeline still advances.
- Read (enable=1, wr=0):
  - Storage is sampled at the issue posedge.
  - Data and a valid bit enter stage 1 of a LATENCY-deep shift pipeline.
  - At the posedge LATENCY cycles after issue, data_out and data_valid are driven from the last stage (registered outputs).
  - Example, LATENCY=4: issue at edge N, data_valid high for the cycle following edge N+4.
- Throughput:
  - Fully pipelined; a new request is accepted every cycle.
  - Back-to-back reads yield back-to-back data_valid pulses, in issue order.
- Idle (enable=0): a bubble enters the pipeline; data_valid=0 for that slot. data_out holds its last value.
- Read-after-write:
  - A read issued the cycle after a write to the same address returns the new data.
  - There is no same-cycle read+write (wr selects one operation).
- Write during in-flight reads: does not alter data already captured in the pipeline.
- Address wrap: only address[ADDR_WIDTH-1:1] are used; no out-of-range condition exists.
- X-safety: with enable=0, the values of wr, address and data_in do not affect any state.
- Pipeline implementation: valid shift register plus data shift register. Alternatively a LATENCY-entry circular buffer with write and read pointers, provided the cycle behaviour is identical.

Optional Feature:
MEM_STALL_EN
- Defined:
  - Adds an input port stall (1 bit) and an output port busy (1 bit).
  - While stall=1, the pipeline freezes: no stage advances, data_valid=0, data_out holds.
  - While stall=1, requests are not accepted and writes are not committed.
  - busy = stall OR (any pipeline valid bit set); it is combinational.
  - When stall drops, the pipeline resumes exactly where it froze, so each read's latency is LATENCY plus the number of stalled cycles.
- Undefined: neither port exists, and the pipeline advances every cycle.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release with enable=0 for 10 cycles -> data_valid=0 and data_out=16'h0000 throughout.
- Write then read: write 16'h4567 to address 16'h0046, read 16'h0046 the next cycle -> data_valid=1 exactly 4 cycles after the read issue, data_out=16'h4567. Address 16'h0047 returns the same word.
- Cache-line fill: write 16'h1000+i to 16'h0040+2i for i=0..7, then issue 8 consecutive reads 16'h0040..16'h004E -> 8 consecutive data_valid pulses starting 4 cycles after the first read, data 16'h1000..16'h1007 in order.
- Bubbles: read A, idle, read B, idle, idle, read C -> data_valid pattern 1,0,1,0,0,1 with the same spacing, each 4 cycles after its issue, correct data.
- Reset mid-fill: issue 3 reads, assert rst=0 for 1 cycle after the 2nd read's issue, release -> no data_valid for any of the 3 reads; stored data is unchanged (verified by a later read).
- MEM_STALL_EN: read 16'h0046, assert stall for 3 cycles starting the cycle after issue -> data_valid appears 7 cycles after issue with 16'h4567, and busy=1 from issue until data_valid.
